axis_escape_framer: RTL and testbench

//  AXI-Stream byte-stuffing encoder in front of the Manchester line TX.

---
 rtl/manchester_pkg.sv | 15 +
 rtl/sat_counter.sv | 26 ++
 rtl/axis_escape_framer.sv | 137 +++++++++++++
 tb/tb_axis_escape_framer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Symbol constants and framer state encoding shared by the Manchester line encoder and decoder.
package manchester_pkg;

  localparam logic [7:0] START_WORD_DEF    = 8'hD5;
  localparam logic [7:0] ESCAPE_SYMBOL_DEF = 8'hE5;
  localparam logic [7:0] START_REPLACE_DEF = 8'hF5;
  localparam logic [7:0] ESC_REPLACE_DEF   = 8'hE5;

  typedef enum logic [1:0] {
    ST_SOF  = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2
  } fr_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear taking priority over a same-cycle increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/axis_escape_framer.sv
// AXI-Stream byte-stuffing encoder: escapes delimiter/escape symbols, optionally prefixes frames
// with the start word, and keeps saturating escape/frame statistics.
module axis_escape_framer
  import manchester_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] START_WORD    = DATA_WIDTH'(START_WORD_DEF),
  parameter logic [DATA_WIDTH-1:0] ESCAPE_SYMBOL = DATA_WIDTH'(ESCAPE_SYMBOL_DEF),
  parameter logic [DATA_WIDTH-1:0] START_REPLACE = DATA_WIDTH'(START_REPLACE_DEF),
  parameter logic [DATA_WIDTH-1:0] ESC_REPLACE   = DATA_WIDTH'(ESC_REPLACE_DEF),
  parameter bit                    INSERT_START  = 1'b1,
  parameter int unsigned           CNT_WIDTH     = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic                  cfg_bypass,
  input  logic                  stat_clear,
  output logic [CNT_WIDTH-1:0]  esc_count,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  // Escape sequences would be ambiguous to the decoder with these symbol choices.
  if ((START_WORD == ESCAPE_SYMBOL) ||
      (START_REPLACE == START_WORD) || (START_REPLACE == ESCAPE_SYMBOL) ||
      (ESC_REPLACE == START_WORD)) begin : g_bad_symbols
    $error("axis_escape_framer: conflicting START/ESCAPE/replacement symbols");
  end

  fr_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] rep_q, rep_d;
  logic                  rep_last_q, rep_last_d;
  logic                  out_free;
  logic                  esc_inc;
  logic                  frame_inc;

  assign out_free      = !tvalid_q || m_axis_tready;
  assign s_axis_tready = out_free &&
                         ((state_q == ST_BODY) || ((state_q == ST_SOF) && !INSERT_START));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_SOF;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      rep_q      <= '0;
      rep_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      rep_q      <= rep_d;
      rep_last_q <= rep_last_d;
    end
  end

  // Next state and output register load; nothing moves while the output is stalled.
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    rep_d      = rep_q;
    rep_last_d = rep_last_q;
    esc_inc    = 1'b0;
    if (out_free) begin
      tvalid_d = 1'b0;
      case (state_q)
        ST_TAIL: begin
          tdata_d  = rep_q;
          tlast_d  = rep_last_q;
          tvalid_d = 1'b1;
          state_d  = rep_last_q ? ST_SOF : ST_BODY;
        end
        default: begin
          if ((state_q == ST_SOF) && INSERT_START) begin
            if (s_axis_tvalid) begin
              tdata_d  = START_WORD;
              tlast_d  = 1'b0;
              tvalid_d = 1'b1;
              state_d  = ST_BODY;
            end
          end else if (s_axis_tvalid) begin
            tvalid_d = 1'b1;
            if (!cfg_bypass &&
                ((s_axis_tdata == START_WORD) || (s_axis_tdata == ESCAPE_SYMBOL))) begin
              tdata_d    = ESCAPE_SYMBOL;
              tlast_d    = 1'b0;
              rep_d      = (s_axis_tdata == START_WORD) ? START_REPLACE : ESC_REPLACE;
              rep_last_d = s_axis_tlast;
              esc_inc    = 1'b1;
              state_d    = ST_TAIL;
            end else begin
              tdata_d = s_axis_tdata;
              tlast_d = s_axis_tlast;
              state_d = s_axis_tlast ? ST_SOF : ST_BODY;
            end
          end
        end
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_inc     = tvalid_q && m_axis_tready && tlast_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_esc_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc_i   (esc_inc),
    .clr_i   (stat_clear),
    .count_o (esc_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc_i   (frame_inc),
    .clr_i   (stat_clear),
    .count_o (frame_count)
  );

endmodule

// File: tb/tb_axis_escape_framer.sv
// Directed bench for axis_escape_framer: instance A uses defaults, instance B has
// INSERT_START=0 and a 2-bit counter to reach bypass and saturation corners.
module tb_axis_escape_framer;

  logic        aclk = 1'b0;
  logic        aresetn;

  logic [7:0]  a_tdata, a_mdata;
  logic        a_tvalid, a_tready, a_tlast, a_mvalid, a_mready, a_mlast, a_bypass, a_clr;
  logic [15:0] a_esc, a_frm;

  logic [7:0]  b_tdata, b_mdata;
  logic        b_tvalid, b_tready, b_tlast, b_mvalid, b_mready, b_mlast, b_bypass, b_clr;
  logic [1:0]  b_esc, b_frm;

  int vec_cnt  = 0;
  int fail_cnt = 0;
  int cyc      = 0;

  logic [8:0] a_q[$];
  int         a_cyc_q[$];
  logic [8:0] b_q[$];

  always #5 aclk = ~aclk;

  axis_escape_framer u_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready), .s_axis_tlast(a_tlast),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready), .m_axis_tlast(a_mlast),
    .cfg_bypass(a_bypass), .stat_clear(a_clr), .esc_count(a_esc), .frame_count(a_frm)
  );

  axis_escape_framer #(.INSERT_START(1'b0), .CNT_WIDTH(2)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tlast(b_tlast),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready), .m_axis_tlast(b_mlast),
    .cfg_bypass(b_bypass), .stat_clear(b_clr), .esc_count(b_esc), .frame_count(b_frm)
  );

  // Record every symbol that the next rising edge will hand downstream.
  always @(negedge aclk) begin
    cyc <= cyc + 1;
    if (aresetn && a_mvalid && a_mready) begin
      a_q.push_back({a_mlast, a_mdata});
      a_cyc_q.push_back(cyc);
    end
    if (aresetn && b_mvalid && b_mready) b_q.push_back({b_mlast, b_mdata});
  end

  task automatic send_a(input logic [7:0] d, input logic l, output bit ok);
    a_tdata = d; a_tlast = l; a_tvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (a_tready) begin
        @(posedge aclk); #1;
        ok = 1'b1;
        break;
      end
    end
    a_tvalid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l, output bit ok);
    b_tdata = d; b_tlast = l; b_tvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (b_tready) begin
        @(posedge aclk); #1;
        ok = 1'b1;
        break;
      end
    end
    b_tvalid = 1'b0;
  endtask

  task automatic drain(input bit use_b, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if ((use_b ? b_q.size() : a_q.size()) >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge aclk);
  endtask

  task automatic clear_stats;
    @(posedge aclk); #1;
    a_clr = 1'b1; b_clr = 1'b1;
    @(posedge aclk); #1;
    a_clr = 1'b0; b_clr = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge aclk);
    vec_cnt++;
    if (a_mvalid !== 1'b0 || a_mdata !== 8'h00 || a_mlast !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_out: got v=%b d=%h l=%b want 0 00 0", a_mvalid, a_mdata, a_mlast);
    end
    vec_cnt++;
    if (a_esc !== 16'd0 || a_frm !== 16'd0) begin
      fail_cnt++;
      $display("FAIL reset_cnt: got esc=%0d frm=%0d want 0 0", a_esc, a_frm);
    end
    vec_cnt++;
    if (a_tready !== 1'b0 || b_tready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_ready: got a=%b b=%b want 0 1", a_tready, b_tready);
    end
  endtask

  task automatic test_plain_frame;
    bit ok, all_ok;
    logic [8:0] exp [4];
    exp = '{9'h0D5, 9'h011, 9'h022, 9'h133};
    clear_stats();
    a_q.delete(); a_cyc_q.delete();
    all_ok = 1'b1;
    send_a(8'h11, 1'b0, ok); all_ok &= ok;
    send_a(8'h22, 1'b0, ok); all_ok &= ok;
    send_a(8'h33, 1'b1, ok); all_ok &= ok;
    drain(1'b0, 4, ok); all_ok &= ok;
    vec_cnt++;
    if (!all_ok || a_q.size() != 4) begin
      fail_cnt++;
      $display("FAIL plain_len: got %0d symbols want 4", a_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vec_cnt++;
        if (a_q[i] !== exp[i]) begin
          fail_cnt++;
          $display("FAIL plain_sym%0d: got %h want %h", i, a_q[i], exp[i]);
        end
      end
      vec_cnt++;
      if (a_cyc_q[3] - a_cyc_q[0] != 3) begin
        fail_cnt++;
        $display("FAIL plain_rate: got span %0d cycles want 3", a_cyc_q[3] - a_cyc_q[0]);
      end
    end
    vec_cnt++;
    if (a_frm !== 16'd1 || a_esc !== 16'd0) begin
      fail_cnt++;
      $display("FAIL plain_cnt: got frm=%0d esc=%0d want 1 0", a_frm, a_esc);
    end
  endtask

  task automatic test_escape;
    bit ok, all_ok;
    logic [8:0] exp [5];
    exp = '{9'h0D5, 9'h0E5, 9'h0F5, 9'h0E5, 9'h1E5};
    clear_stats();
    a_q.delete();
    all_ok = 1'b1;
    send_a(8'hD5, 1'b0, ok); all_ok &= ok;
    @(negedge aclk);
    vec_cnt++;
    if (a_tready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL esc_tail_ready1: got %b want 0", a_tready);
    end
    send_a(8'hE5, 1'b1, ok); all_ok &= ok;
    @(negedge aclk);
    vec_cnt++;
    if (a_tready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL esc_tail_ready2: got %b want 0", a_tready);
    end
    drain(1'b0, 5, ok); all_ok &= ok;
    vec_cnt++;
    if (!all_ok || a_q.size() != 5) begin
      fail_cnt++;
      $display("FAIL esc_len: got %0d symbols want 5", a_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vec_cnt++;
        if (a_q[i] !== exp[i]) begin
          fail_cnt++;
          $display("FAIL esc_sym%0d: got %h want %h", i, a_q[i], exp[i]);
        end
      end
    end
    vec_cnt++;
    if (a_esc !== 16'd2 || a_frm !== 16'd1) begin
      fail_cnt++;
      $display("FAIL esc_cnt: got esc=%0d frm=%0d want 2 1", a_esc, a_frm);
    end
  endtask

  task automatic test_backpressure;
    logic [8:0] exp[$];
    bit         done, all_ok, ok;
    int         bad;
    clear_stats();
    a_q.delete();
    done = 1'b0; all_ok = 1'b1; bad = 0;
    fork
      begin
        for (int f = 0; f < 1000; f++) begin
          int len;
          len = $urandom_range(1, 4);
          exp.push_back(9'h0D5);
          for (int k = 0; k < len; k++) begin
            logic [7:0] d;
            logic       l;
            int         r;
            r = $urandom_range(0, 3);
            d = (r == 0) ? 8'hD5 : (r == 1) ? 8'hE5 : 8'($urandom_range(0, 255));
            l = (k == len - 1);
            if (d == 8'hD5) begin
              exp.push_back(9'h0E5); exp.push_back({l, 8'hF5});
            end else if (d == 8'hE5) begin
              exp.push_back(9'h0E5); exp.push_back({l, 8'hE5});
            end else begin
              exp.push_back({l, d});
            end
            send_a(d, l, ok); all_ok &= ok;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge aclk); #1;
          a_mready = 1'($urandom_range(0, 1));
        end
        a_mready = 1'b1;
      end
      begin
        logic       stalled;
        logic [8:0] held;
        stalled = 1'b0; held = '0;
        while (!done) begin
          @(negedge aclk);
          if (stalled) begin
            vec_cnt++;
            if (a_mvalid !== 1'b1 || {a_mlast, a_mdata} !== held) begin
              fail_cnt++;
              $display("FAIL bp_stable: got v=%b %h want 1 %h", a_mvalid, {a_mlast, a_mdata}, held);
            end
          end
          stalled = a_mvalid && !a_mready;
          held    = {a_mlast, a_mdata};
        end
      end
    join
    drain(1'b0, exp.size(), ok); all_ok &= ok;
    vec_cnt++;
    if (!all_ok || a_q.size() != exp.size()) begin
      fail_cnt++;
      $display("FAIL bp_len: got %0d symbols want %0d", a_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) if (a_q[i] !== exp[i]) bad++;
      vec_cnt++;
      if (bad != 0) begin
        fail_cnt++;
        $display("FAIL bp_data: got %0d wrong symbols want 0", bad);
      end
    end
    vec_cnt++;
    if (a_frm !== 16'd1000) begin
      fail_cnt++;
      $display("FAIL bp_frames: got %0d want 1000", a_frm);
    end
  endtask

  task automatic test_bypass;
    bit ok, all_ok;
    clear_stats();
    b_q.delete();
    b_bypass = 1'b1; all_ok = 1'b1;
    send_b(8'hD5, 1'b0, ok); all_ok &= ok;
    send_b(8'hE5, 1'b1, ok); all_ok &= ok;
    drain(1'b1, 2, ok); all_ok &= ok;
    b_bypass = 1'b0;
    vec_cnt++;
    if (!all_ok || b_q.size() != 2) begin
      fail_cnt++;
      $display("FAIL byp_len: got %0d symbols want 2", b_q.size());
    end else begin
      vec_cnt++;
      if (b_q[0] !== 9'h0D5 || b_q[1] !== 9'h1E5) begin
        fail_cnt++;
        $display("FAIL byp_data: got %h %h want 0d5 1e5", b_q[0], b_q[1]);
      end
    end
    vec_cnt++;
    if (b_esc !== 2'd0 || b_frm !== 2'd1) begin
      fail_cnt++;
      $display("FAIL byp_cnt: got esc=%0d frm=%0d want 0 1", b_esc, b_frm);
    end
  endtask

  task automatic test_saturate;
    bit ok, all_ok;
    clear_stats();
    b_q.delete();
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_b(8'hE5, (i == 4), ok); all_ok &= ok;
    end
    drain(1'b1, 10, ok); all_ok &= ok;
    vec_cnt++;
    if (!all_ok || b_esc !== 2'd3) begin
      fail_cnt++;
      $display("FAIL sat_esc: got %0d want 3", b_esc);
    end
    b_clr = 1'b1;
    send_b(8'hE5, 1'b1, ok);
    b_clr = 1'b0;
    @(negedge aclk);
    vec_cnt++;
    if (!ok || b_esc !== 2'd0) begin
      fail_cnt++;
      $display("FAIL sat_clr: got %0d want 0", b_esc);
    end
    drain(1'b1, 12, ok);
    vec_cnt++;
    if (!ok || b_esc !== 2'd0 || b_q[11] !== 9'h1E5) begin
      fail_cnt++;
      $display("FAIL sat_tail: got esc=%0d ok=%b want 0 1", b_esc, ok);
    end
  endtask

  task automatic test_reset_in_tail;
    bit ok, all_ok;
    all_ok = 1'b1;
    a_mready = 1'b1;
    send_a(8'hD5, 1'b1, ok); all_ok &= ok;
    a_mready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    vec_cnt++;
    if (!all_ok || a_mvalid !== 1'b0 || a_tready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL rst_tail: got v=%b rdy=%b want 0 0", a_mvalid, a_tready);
    end
    a_q.delete();
    a_mready = 1'b1;
    send_a(8'h11, 1'b1, ok); all_ok &= ok;
    drain(1'b0, 2, ok); all_ok &= ok;
    vec_cnt++;
    if (!all_ok || a_q.size() != 2 || a_q[0] !== 9'h0D5 || a_q[1] !== 9'h111) begin
      fail_cnt++;
      $display("FAIL rst_next: got %0d symbols first=%h want 2 0d5,111", a_q.size(),
               (a_q.size() > 0) ? a_q[0] : 9'h000);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    a_tdata = '0; a_tvalid = 1'b0; a_tlast = 1'b0; a_mready = 1'b1; a_bypass = 1'b0; a_clr = 1'b0;
    b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_mready = 1'b1; b_bypass = 1'b0; b_clr = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    test_reset();
    test_plain_frame();
    test_escape();
    test_backpressure();
    test_bypass();
    test_saturate();
    test_reset_in_tail();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
